// File: rtl/tournament_predictor_if.sv
// Fetch-side prediction and execute-side training signals of the tournament predictor.
// The master side belongs to the pipeline and the slave side to the predictor.
interface tournament_predictor_if #(
   parameter int BHR_SIZE = 7
);
   logic [31:0]         pc_if;
   logic                is_branch_if;
   logic                predict_taken;
   logic                glob_predict_taken_if;
   logic                loc_predict_taken_if;
   logic [BHR_SIZE-1:0] bhr_if;
   logic                valid_branch;
   logic [31:0]         pc_ex;
   logic [BHR_SIZE-1:0] bhr_ex;
   logic                glob_predict_taken_ex;
   logic                loc_predict_taken_ex;
   logic                predict_taken_ex;
   logic                cmp_out_ex;
   logic                mispredict;
   logic [31:0]         branch_cnt;
   logic [31:0]         mispredict_cnt;

   modport master (
      output pc_if, is_branch_if, valid_branch, pc_ex, bhr_ex,
             glob_predict_taken_ex, loc_predict_taken_ex, predict_taken_ex, cmp_out_ex,
      input  predict_taken, glob_predict_taken_if, loc_predict_taken_if, bhr_if,
             mispredict, branch_cnt, mispredict_cnt
   );

   modport slave (
      input  pc_if, is_branch_if, valid_branch, pc_ex, bhr_ex,
             glob_predict_taken_ex, loc_predict_taken_ex, predict_taken_ex, cmp_out_ex,
      output predict_taken, glob_predict_taken_if, loc_predict_taken_if, bhr_if,
             mispredict, branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/tournament_predictor.sv
// Tournament branch predictor: gshare + two-level local, per-PC chooser, speculative GHR.
// Predicts combinationally in IF; trains from the snapshot carried down to EX.
module tournament_predictor #(
   parameter int BHR_SIZE    = 7,
   parameter int LHT_IDX     = 5,
   parameter int LHR_SIZE    = 7,
   parameter int CHOOSER_IDX = 7,
   parameter int CTR_W       = 2
) (
   input logic                   clk,
   input logic                   rst,
   tournament_predictor_if.slave bus
);
   localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};
   localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
   localparam logic [CTR_W-1:0] CTR_WG  = {1'b1, {(CTR_W-1){1'b0}}};

   logic [CTR_W-1:0]    gpht    [2**BHR_SIZE];
   logic [CTR_W-1:0]    lpht    [2**LHR_SIZE];
   logic [LHR_SIZE-1:0] lht     [2**LHT_IDX];
   logic [CTR_W-1:0]    chooser [2**CHOOSER_IDX];

   logic [BHR_SIZE-1:0]    ghr;
   logic [31:0]            branch_cnt_q;
   logic [31:0]            mispredict_cnt_q;
   logic [BHR_SIZE-1:0]    g_rd_idx, g_wr_idx;
   logic [LHT_IDX-1:0]     lht_rd_idx, lht_wr_idx;
   logic [LHR_SIZE-1:0]    lh_rd, lh_wr;
   logic [CHOOSER_IDX-1:0] ch_rd_idx, ch_wr_idx;
   logic                   glob_rd, loc_rd, misp;
   logic                   unused_pc;

   function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
      if (up)
         return (c == CTR_MAX) ? c : c + CTR_ONE;
      return (c == '0) ? c : c - CTR_ONE;
   endfunction

   // Only a slice of each PC feeds the index hashes.
   assign unused_pc = ^{bus.pc_if, bus.pc_ex};

   assign g_rd_idx   = bus.pc_if[BHR_SIZE+1:2] ^ ghr;
   assign lht_rd_idx = bus.pc_if[LHT_IDX+1:2];
   assign lh_rd      = lht[lht_rd_idx];
   assign ch_rd_idx  = bus.pc_if[CHOOSER_IDX+1:2];
   assign glob_rd    = gpht[g_rd_idx][CTR_W-1];
   assign loc_rd     = lpht[lh_rd][CTR_W-1];

   assign bus.glob_predict_taken_if = glob_rd;
   assign bus.loc_predict_taken_if  = loc_rd;
   assign bus.predict_taken         = chooser[ch_rd_idx][CTR_W-1] ? glob_rd : loc_rd;
   assign bus.bhr_if                = ghr;

   assign g_wr_idx   = bus.pc_ex[BHR_SIZE+1:2] ^ bus.bhr_ex;
   assign lht_wr_idx = bus.pc_ex[LHT_IDX+1:2];
   assign lh_wr      = lht[lht_wr_idx];
   assign ch_wr_idx  = bus.pc_ex[CHOOSER_IDX+1:2];

   assign misp               = bus.valid_branch & (bus.predict_taken_ex != bus.cmp_out_ex);
   assign bus.mispredict     = misp;
   assign bus.branch_cnt     = branch_cnt_q;
   assign bus.mispredict_cnt = mispredict_cnt_q;

   // Table writes take effect at the edge, so an IF read of the same entry sees the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**BHR_SIZE; i++)    gpht[i]    <= CTR_WNT;
         for (int i = 0; i < 2**LHR_SIZE; i++)    lpht[i]    <= CTR_WNT;
         for (int i = 0; i < 2**LHT_IDX; i++)     lht[i]     <= '0;
         for (int i = 0; i < 2**CHOOSER_IDX; i++) chooser[i] <= CTR_WG;
      end else if (bus.valid_branch) begin
         gpht[g_wr_idx]   <= ctr_step(gpht[g_wr_idx], bus.cmp_out_ex);
         lpht[lh_wr]      <= ctr_step(lpht[lh_wr], bus.cmp_out_ex);
         lht[lht_wr_idx]  <= {lh_wr[LHR_SIZE-2:0], bus.cmp_out_ex};
         if (bus.glob_predict_taken_ex != bus.loc_predict_taken_ex)
            chooser[ch_wr_idx] <= ctr_step(chooser[ch_wr_idx],
                                           bus.glob_predict_taken_ex == bus.cmp_out_ex);
      end
   end

   // Repair from the EX snapshot wins over the speculative IF shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ghr <= '0;
      else if (misp)
         ghr <= {bus.bhr_ex[BHR_SIZE-2:0], bus.cmp_out_ex};
      else if (bus.is_branch_if)
         ghr <= {ghr[BHR_SIZE-2:0], bus.predict_taken};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else if (bus.valid_branch) begin
         if (branch_cnt_q != 32'hFFFF_FFFF)
            branch_cnt_q <= branch_cnt_q + 32'd1;
         if (misp && (mispredict_cnt_q != 32'hFFFF_FFFF))
            mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_tournament_predictor.sv
// Self-checking bench for tournament_predictor: behavioural reference model feeding a scoreboard,
// directed scenarios followed by random traffic.
module tb_tournament_predictor;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   tournament_predictor_if bus ();
   tournament_predictor dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic        pred, glob, loc, misp;
      logic [6:0]  bhr;
      logic [31:0] bc, mc;
   } exp_t;
   exp_t sb[$];

   int     mg  [128];
   int     ml  [128];
   int     mch [128];
   int     mlh [32];
   int     mghr;
   longint mbc, mmc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int c, input bit up);
      if (up) return (c >= 3) ? 3 : c + 1;
      return (c <= 0) ? 0 : c - 1;
   endfunction

   function automatic longint sat32(input longint c);
      return (c >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : c + 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 128; i++) begin mg[i] = 1; ml[i] = 1; mch[i] = 2; end
      for (int i = 0; i < 32; i++) mlh[i] = 0;
      mghr = 0; mbc = 0; mmc = 0;
   endtask

   // {pred, glob, loc} the model predicts for a fetch PC under the current model state
   function automatic logic [2:0] model_pred(input logic [31:0] pc);
      int  w;
      bit  g, l, c;
      w = int'(pc >> 2);
      g = mg[(w & 127) ^ mghr] >= 2;
      l = ml[mlh[w & 31]] >= 2;
      c = mch[w & 127] >= 2;
      return {c ? g : l, g, l};
   endfunction

   task automatic step(input logic [31:0] pc, input logic isb, input logic vb,
                       input logic [31:0] pcex, input logic [6:0] bhrex,
                       input logic gex, input logic lex, input logic pex, input logic cmp);
      exp_t       e, o;
      logic [2:0] p;
      int         w, h;
      bus.pc_if = pc; bus.is_branch_if = isb; bus.valid_branch = vb; bus.pc_ex = pcex;
      bus.bhr_ex = bhrex; bus.glob_predict_taken_ex = gex; bus.loc_predict_taken_ex = lex;
      bus.predict_taken_ex = pex; bus.cmp_out_ex = cmp;
      #1;
      p = model_pred(pc);
      e.pred = p[2]; e.glob = p[1]; e.loc = p[0];
      e.misp = vb && (pex != cmp);
      e.bhr  = 7'(mghr);
      e.bc   = 32'(mbc); e.mc = 32'(mmc);
      sb.push_back(e);
      o = sb.pop_front();
      chk("pred", {31'd0, bus.predict_taken}, {31'd0, o.pred});
      chk("glob", {31'd0, bus.glob_predict_taken_if}, {31'd0, o.glob});
      chk("loc", {31'd0, bus.loc_predict_taken_if}, {31'd0, o.loc});
      chk("misp", {31'd0, bus.mispredict}, {31'd0, o.misp});
      chk("bhr_if", {25'd0, bus.bhr_if}, {25'd0, o.bhr});
      chk("branch_cnt", bus.branch_cnt, o.bc);
      chk("mispredict_cnt", bus.mispredict_cnt, o.mc);
      if (vb) begin
         w = int'(pcex >> 2);
         mg[(w & 127) ^ int'(bhrex)] = sat(mg[(w & 127) ^ int'(bhrex)], cmp);
         h = mlh[w & 31];
         ml[h] = sat(ml[h], cmp);
         mlh[w & 31] = ((h << 1) | int'(cmp)) & 127;
         if (gex != lex) mch[w & 127] = sat(mch[w & 127], gex == cmp);
         mbc = sat32(mbc);
         if (e.misp) mmc = sat32(mmc);
      end
      if (e.misp) mghr = ((int'(bhrex) << 1) | int'(cmp)) & 127;
      else if (isb) mghr = ((mghr << 1) | int'(e.pred)) & 127;
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [2:0]  mp;
   logic [31:0] pcs [6];
   logic [31:0] rpc;
   bit          pat;

   initial begin
      pcs[0] = 32'h40; pcs[1] = 32'h100; pcs[2] = 32'h200;
      pcs[3] = 32'h300; pcs[4] = 32'h1044; pcs[5] = 32'h2F8;
      rst = 1'b1;
      bus.pc_if = '0; bus.is_branch_if = 0; bus.valid_branch = 0; bus.pc_ex = '0;
      bus.bhr_ex = '0; bus.glob_predict_taken_ex = 0; bus.loc_predict_taken_ex = 0;
      bus.predict_taken_ex = 0; bus.cmp_out_ex = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 1: reset state, first fetch
      bus.pc_if = 32'h100; bus.is_branch_if = 1;
      #1;
      chk("t1_pred", {31'd0, bus.predict_taken}, 32'd0);
      chk("t1_glob", {31'd0, bus.glob_predict_taken_if}, 32'd0);
      chk("t1_loc", {31'd0, bus.loc_predict_taken_if}, 32'd0);
      chk("t1_bhr", {25'd0, bus.bhr_if}, 32'd0);
      step(32'h100, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("t1_bhr_next", {25'd0, bus.bhr_if}, 32'd0);

      // 2: two taken trains on gshare entry for 0x200
      repeat (2) step(32'h0, 0, 1, 32'h200, 7'h00, 1, 0, 1, 1);
      bus.pc_if = 32'h200; bus.is_branch_if = 0; bus.valid_branch = 0;
      #1;
      chk("t2_glob", {31'd0, bus.glob_predict_taken_if}, 32'd1);
      chk("t2_pred", {31'd0, bus.predict_taken}, 32'd1);
      step(32'h200, 0, 0, 0, 0, 0, 0, 0, 0);

      // 3: local T,T,T,N loop on 0x40
      for (int it = 0; it < 20; it++) begin
         for (int k = 0; k < 4; k++) begin
            pat = (k != 3);
            mp = model_pred(32'h40);
            if (it >= 12) begin
               bus.pc_if = 32'h40; bus.is_branch_if = 0; bus.valid_branch = 0;
               #1;
               chk("t3_loc", {31'd0, bus.loc_predict_taken_if}, {31'd0, pat});
               chk("t3_pred", {31'd0, bus.predict_taken}, {31'd0, pat});
            end
            step(32'h40, 0, 1, 32'h40, 7'(mghr), mp[1], mp[0], mp[2], pat);
         end
      end

      // 4: repair beats IF shift
      step(32'h500, 1, 1, 32'h600, 7'h15, 0, 0, 0, 1);
      chk("t4_ghr_repair", {25'd0, bus.bhr_if}, 32'h2B);

      // 5: gshare counter saturation, entry (0x300[8:2]) ^ 7'h11
      repeat (4) step(32'h0, 0, 1, 32'h300, 7'h11, 1, 1, 1, 1);
      bus.pc_if = 32'((32'h51 ^ mghr) << 2); bus.valid_branch = 0; bus.is_branch_if = 0;
      #1;
      chk("t5_sat_taken", {31'd0, bus.glob_predict_taken_if}, 32'd1);
      step(32'h0, 0, 1, 32'h300, 7'h11, 0, 0, 0, 0);
      bus.pc_if = 32'((32'h51 ^ mghr) << 2); bus.valid_branch = 0;
      #1;
      chk("t5_after_nt", {31'd0, bus.glob_predict_taken_if}, 32'd1);
      step(bus.pc_if, 0, 0, 0, 0, 0, 0, 0, 0);

      // 5b: branch counter holds at all-ones
      force dut.branch_cnt_q = 32'hFFFF_FFFF;
      mbc = 64'hFFFF_FFFF;
      step(32'h0, 0, 1, 32'h1000, 7'h00, 0, 0, 0, 0);
      release dut.branch_cnt_q;
      step(32'h0, 0, 1, 32'h1000, 7'h00, 0, 0, 0, 0);
      chk("t5_cnt_hold", bus.branch_cnt, 32'hFFFF_FFFF);

      // 6: async reset mid-stream
      step(32'h0, 0, 1, 32'h800, 7'h7F, 0, 0, 0, 1);
      chk("t6_ghr_full", {25'd0, bus.bhr_if}, 32'h7F);
      rst = 1'b1;
      #1;
      chk("t6_bhr_rst", {25'd0, bus.bhr_if}, 32'd0);
      chk("t6_bcnt_rst", bus.branch_cnt, 32'd0);
      chk("t6_mcnt_rst", bus.mispredict_cnt, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(32'h100, 1, 0, 0, 0, 0, 0, 0, 0);

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         rpc = pcs[$urandom_range(0, 5)];
         step(pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              rpc, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
